comparator_unit: RTL and testbench
==================================

Name: comparator_unit

Overview:
- Registered M-bit magnitude comparator used as a compare primitive inside an execution unit of the APB-attached ALU.
- Samples two operands when enabled and produces a primary greater-than flag o_y, plus equal/less-than side flags and a valid strobe.
- Latency is one clock.

Parameters:
- M, 8, operand width in bits (legal M >= 2).
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement signed compare.

Ports:
- i_clk  input  1  system clock; all state updates on rising edge.
- i_rst  input  1  synchronous reset, active high.
- i_en  input  1  operand-valid strobe; compare is performed in any cycle where i_en=1.
- i_argA  input  M  operand A.
- i_argB  input  M  operand B.
- o_y  output  1  registered result: 1 when A > B, else 0.
- o_eq  output  1  registered flag: 1 when A == B.
- o_lt  output  1  registered flag: 1 when A < B.
- o_valid  output  1  high for exactly one cycle after each enabled compare.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: on a rising edge with i_rst=1, o_y, o_eq, o_lt and o_valid all become 0. Reset has priority over i_en.
- Compare:
  - On a rising edge with i_rst=0 and i_en=1, register o_y=(A>B), o_eq=(A==B), o_lt=(A<B) and set o_valid=1.
  - Results are visible the cycle after sampling (latency 1).
  - Exactly one of o_y/o_eq/o_lt is 1 after any enabled compare (one-hot invariant).
- Idle: on a rising edge with i_rst=0 and i_en=0, o_y/o_eq/o_lt hold their previous values and o_valid=0.
- Back-to-back: i_en held high compares every cycle; each result appears one cycle after its operands, with no bubbles.
- Arithmetic:
  - SIGNED=0: operands are unsigned 0..2^M-1.
  - SIGNED=1: operands are two's complement; MSB is the sign, so 8'h80 < 8'h7F.
  - No overflow is possible; equality is bitwise.
- Reset mid-stream: a reset asserted while i_en=1 discards that cycle's operands; there is no o_valid for them.
- Inputs are not registered beyond the output stage. Operands only need to be stable at the sampling edge.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert i_rst for 2 cycles with i_en=1, A=5, B=3 -> o_y=0, o_eq=0, o_lt=0, o_valid=0 throughout reset.
- Basic ordering (M=8, SIGNED=0), i_en=1 in each cycle:
  - A=11, B=14 -> next cycle o_y=0, o_lt=1, o_eq=0, o_valid=1.
  - A=11, B=9 -> o_y=1, o_lt=0, o_eq=0.
  - A=10, B=10 -> o_y=0, o_eq=1, o_lt=0.
- Boundaries unsigned:
  - A=255, B=0 -> o_y=1.
  - A=0, B=255 -> o_lt=1.
  - A=B=0 and A=B=255 -> o_eq=1.
- Signed mode (SIGNED=1):
  - A=8'h80 (-128), B=8'h7F (127) -> o_lt=1.
  - A=8'hFF (-1), B=8'h00 -> o_lt=1.
  - A=8'h01, B=8'hFF -> o_y=1.
- Hold/valid:
  - After A=11, B=9 with i_en=1, drop i_en and change A=0, B=200 -> o_y stays 1, o_valid=0 on all idle cycles.
- Pipelined stream and reset priority:
  - i_en=1 for 4 cycles with pairs (1,2),(2,1),(3,3),(7,4) -> o_y sequence 0,1,0,1 and o_valid=1 each following cycle.
  - Assert i_rst on the third pair -> outputs 0 and no valid for that pair.

Source files
------------

// File: rtl/comparator_unit_if.sv
// rtl/comparator_unit_if.sv - operand/result bundle for the registered magnitude comparator
interface comparator_unit_if #(
    parameter int M = 8
);
    logic         i_en;
    logic [M-1:0] i_argA;
    logic [M-1:0] i_argB;
    logic         o_y;
    logic         o_eq;
    logic         o_lt;
    logic         o_valid;

    modport master (
        output i_en, i_argA, i_argB,
        input  o_y, o_eq, o_lt, o_valid
    );

    modport slave (
        input  i_en, i_argA, i_argB,
        output o_y, o_eq, o_lt, o_valid
    );
endinterface

// File: rtl/comparator_unit.sv
// rtl/comparator_unit.sv - one-cycle registered A>B / A==B / A<B comparator, unsigned or signed
module comparator_unit #(
    parameter int M      = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    comparator_unit_if.slave  bus
);
    logic [M-1:0] w_a;
    logic [M-1:0] w_b;
    logic         w_gt;
    logic         w_eq;
    logic         w_lt;

    logic r_y;
    logic r_eq;
    logic r_lt;
    logic r_valid;

    // Flipping the sign bit maps two's complement order onto unsigned order,
    // so one unsigned comparator serves both modes.
    always_comb begin
        w_a  = {bus.i_argA[M-1] ^ SIGNED, bus.i_argA[M-2:0]};
        w_b  = {bus.i_argB[M-1] ^ SIGNED, bus.i_argB[M-2:0]};
        w_eq = (bus.i_argA == bus.i_argB);
        w_gt = (w_a > w_b);
        w_lt = !w_gt && !w_eq;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_y     <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_valid <= 1'b0;
        end else if (bus.i_en) begin
            r_y     <= w_gt;
            r_eq    <= w_eq;
            r_lt    <= w_lt;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign bus.o_y     = r_y;
    assign bus.o_eq    = r_eq;
    assign bus.o_lt    = r_lt;
    assign bus.o_valid = r_valid;
endmodule

// File: tb/tb_comparator_unit.sv
// tb/tb_comparator_unit.sv - directed vectors against unsigned and signed comparator instances
module tb_comparator_unit;
    logic clk;
    logic rst;

    comparator_unit_if #(.M(8)) u_if ();
    comparator_unit_if #(.M(8)) s_if ();

    comparator_unit #(.M(8), .SIGNED(1'b0)) dut_u (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (u_if)
    );

    comparator_unit #(.M(8), .SIGNED(1'b1)) dut_s (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (s_if)
    );

    always #5 clk = ~clk;

    // {y, eq, lt} expectations for the unsigned and signed instances
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] ue;
        logic [2:0] se;
    } vec_t;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;
    localparam logic [2:0] ZZ = 3'b000;

    vec_t vecs [12];
    int   n_vec;
    int   n_bad;

    task automatic drive(input logic r, input logic e, input logic [7:0] a, input logic [7:0] b);
        rst         = r;
        u_if.i_en   = e;
        s_if.i_en   = e;
        u_if.i_argA = a;
        u_if.i_argB = b;
        s_if.i_argA = a;
        s_if.i_argB = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got y/eq/lt/valid=%b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_both(input string name, input logic [2:0] ue, input logic [2:0] se, input logic v);
        chk({name, " unsigned"}, {u_if.o_y, u_if.o_eq, u_if.o_lt, u_if.o_valid}, {ue, v});
        chk({name, " signed"},   {s_if.o_y, s_if.o_eq, s_if.o_lt, s_if.o_valid}, {se, v});
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        clk   = 1'b0;

        vecs[0]  = '{8'd11,  8'd14,  LT, LT};
        vecs[1]  = '{8'd11,  8'd9,   GT, GT};
        vecs[2]  = '{8'd10,  8'd10,  EQ, EQ};
        vecs[3]  = '{8'd255, 8'd0,   GT, LT};
        vecs[4]  = '{8'd0,   8'd255, LT, GT};
        vecs[5]  = '{8'd0,   8'd0,   EQ, EQ};
        vecs[6]  = '{8'd255, 8'd255, EQ, EQ};
        vecs[7]  = '{8'h80,  8'h7F,  GT, LT};
        vecs[8]  = '{8'hFF,  8'h00,  GT, LT};
        vecs[9]  = '{8'h01,  8'hFF,  LT, GT};
        vecs[10] = '{8'h7F,  8'h80,  LT, GT};
        vecs[11] = '{8'h80,  8'h81,  LT, LT};

        // Reset with i_en high: reset wins, no valid
        drive(1'b1, 1'b1, 8'd5, 8'd3);
        chk_both("reset cycle 1", ZZ, ZZ, 1'b0);
        drive(1'b1, 1'b1, 8'd5, 8'd3);
        chk_both("reset cycle 2", ZZ, ZZ, 1'b0);

        // Back-to-back table vectors, one result per cycle
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, vecs[i].a, vecs[i].b);
            chk_both($sformatf("vec %0d", i), vecs[i].ue, vecs[i].se, 1'b1);
        end

        // Hold: flags stay, valid drops while idle with changed operands
        drive(1'b0, 1'b1, 8'd11, 8'd9);
        chk_both("hold load", GT, GT, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 8'd0, 8'd200);
            chk_both($sformatf("hold idle %0d", i), GT, GT, 1'b0);
        end

        // Pipelined stream
        drive(1'b0, 1'b1, 8'd1, 8'd2);
        chk_both("stream 0", LT, LT, 1'b1);
        drive(1'b0, 1'b1, 8'd2, 8'd1);
        chk_both("stream 1", GT, GT, 1'b1);
        drive(1'b0, 1'b1, 8'd3, 8'd3);
        chk_both("stream 2", EQ, EQ, 1'b1);
        drive(1'b0, 1'b1, 8'd7, 8'd4);
        chk_both("stream 3", GT, GT, 1'b1);

        // Reset on the third pair discards it
        drive(1'b0, 1'b1, 8'd1, 8'd2);
        chk_both("rst stream 0", LT, LT, 1'b1);
        drive(1'b0, 1'b1, 8'd2, 8'd1);
        chk_both("rst stream 1", GT, GT, 1'b1);
        drive(1'b1, 1'b1, 8'd3, 8'd3);
        chk_both("rst stream 2", ZZ, ZZ, 1'b0);
        drive(1'b0, 1'b1, 8'd7, 8'd4);
        chk_both("rst stream 3", GT, GT, 1'b1);
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        chk_both("rst stream idle", GT, GT, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
